// File: rtl/br_pkg.sv
`default_nettype none
// ============================================================================
// Module   : br_pkg
// Brief    : Shared types and constants for the branch resolve controller.
// Revision : 1.0
// ============================================================================
package br_pkg;

  localparam logic [0:0]  S_IDLE  = 1'b0;
  localparam logic [0:0]  S_FLUSH = 1'b1;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } br_entry_t;

endpackage
`default_nettype wire

// File: rtl/br_pred_fifo.sv
`default_nettype none
// ============================================================================
// Module   : br_pred_fifo
// Brief    : In-order prediction queue with push/pop/clear and head read.
// Revision : 1.0
// ============================================================================
module br_pred_fifo
  import br_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  br_entry_t push_data,
  input  logic      pop,
  input  logic      clear,
  output logic      full,
  output logic      empty,
  output br_entry_t head
);

  localparam int AW = $clog2(QDEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  br_entry_t   r_mem [QDEPTH];
  logic        w_push_ok;
  logic        w_pop_ok;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign head      = r_mem[r_rd_ptr[AW-1:0]];
  assign w_pop_ok  = pop & ~empty;
  assign w_push_ok = push & (~full | w_pop_ok);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok && !clear) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/br_resolve_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : br_resolve_ctrl
// Brief    : Matches fetch predictions to EX outcomes, flushes on mispredict,
//            schedules predictor updates and keeps branch statistics.
// Revision : 1.0
// ============================================================================
module br_resolve_ctrl
  import br_pkg::*;
#(
  parameter int QDEPTH       = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid_i,
  input  logic [31:0]      pred_pc_i,
  input  logic             pred_taken_i,
  input  logic [31:0]      pred_target_i,
  input  logic             res_valid_i,
  input  logic             res_taken_i,
  input  logic [31:0]      res_target_i,
  output logic             q_full_o,
  output logic             flush_o,
  output logic [31:0]      redirect_pc_o,
  output logic             upd_valid_o,
  output logic             upd_taken_o,
  output logic [31:0]      upd_addr_o,
  output logic [31:0]      upd_target_o,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] mis_cnt_o,
  output logic             err_o
);

  localparam int            FCW          = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCW-1:0] C_FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);

  logic [0:0]       r_state;
  logic [0:0]       w_next_state;
  logic [FCW-1:0]   r_flush_cnt;
  logic [31:0]      r_redirect_pc;
  logic             r_upd_valid;
  logic             r_upd_taken;
  logic [31:0]      r_upd_addr;
  logic [31:0]      r_upd_target;
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_mis_cnt;
  logic             r_err;

  logic      w_idle, w_res, w_pop, w_push, w_mis, w_empty, w_full;
  br_entry_t w_head, w_eff, w_push_data;

  br_pred_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .clear     (w_mis),
    .full      (w_full),
    .empty     (w_empty),
    .head      (w_head)
  );

  assign w_push_data = '{pc: pred_pc_i, taken: pred_taken_i, target: pred_target_i};
  assign w_idle      = (r_state == S_IDLE);
  assign w_res       = res_valid_i & w_idle;
  assign w_pop       = w_res & ~w_empty;
  assign w_push      = pred_valid_i & (~w_full | w_pop) & ~flush_o & w_idle;
  // An empty queue stands in for a not-taken prediction at PC 0.
  assign w_eff       = w_empty ? '0 : w_head;
  assign w_mis       = w_res & ((w_eff.taken != res_taken_i) |
                       (res_taken_i & w_eff.taken & (w_eff.target != res_target_i)));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_mis) w_next_state = S_FLUSH;
      S_FLUSH: if (r_flush_cnt == '0) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    flush_o = (r_state == S_FLUSH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flush_cnt   <= '0;
      r_redirect_pc <= '0;
    end else if (w_mis) begin
      r_flush_cnt   <= C_FLUSH_LOAD;
      r_redirect_pc <= res_taken_i ? res_target_i : (w_eff.pc + PC_STEP);
    end else if (!w_idle && r_flush_cnt != '0) begin
      r_flush_cnt   <= r_flush_cnt - FCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_upd_valid  <= 1'b0;
      r_upd_taken  <= 1'b0;
      r_upd_addr   <= '0;
      r_upd_target <= '0;
      r_br_cnt     <= '0;
      r_mis_cnt    <= '0;
      r_err        <= 1'b0;
    end else begin
      r_upd_valid <= w_res;
      if (w_res) begin
        r_upd_taken  <= res_taken_i;
        r_upd_addr   <= w_eff.pc;
        r_upd_target <= res_target_i;
        if (r_br_cnt != '1) r_br_cnt <= r_br_cnt + CNT_W'(1);
      end
      if (w_mis && r_mis_cnt != '1) r_mis_cnt <= r_mis_cnt + CNT_W'(1);
      if (res_valid_i && (w_empty || !w_idle)) r_err <= 1'b1;
    end
  end

  assign q_full_o      = w_full;
  assign redirect_pc_o = r_redirect_pc;
  assign upd_valid_o   = r_upd_valid;
  assign upd_taken_o   = r_upd_taken;
  assign upd_addr_o    = r_upd_addr;
  assign upd_target_o  = r_upd_target;
  assign br_cnt_o      = r_br_cnt;
  assign mis_cnt_o     = r_mis_cnt;
  assign err_o         = r_err;

endmodule
`default_nettype wire
